// File: rtl/rgb565_gray_pack4_ise.sv
`default_nettype none
// ============================================================================
//  Module   : rgb565_gray_pack4_ise
//  Purpose  : Multi-cycle custom instruction that converts four RGB565 pixels
//             to 8-bit grayscale, one pixel per cycle, through one shared
//             weighting datapath. The four gray bytes are packed into one
//             32-bit result word.
//  Revision : 1.0 - initial release
// ============================================================================
module rgb565_gray_pack4_ise #(
  parameter logic [7:0] customInstructionId = 8'd0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  iseId,
  input  logic [31:0] valueA,
  input  logic [31:0] valueB,
  output logic        done,
  output logic [31:0] result
);

  // Luma weights scaled by 256. The sum is truncated, not rounded, so the
  // output matches the single-pixel grayscale instruction bit for bit.
  localparam logic [15:0] C_WEIGHT_R = 16'd54;
  localparam logic [15:0] C_WEIGHT_G = 16'd183;
  localparam logic [15:0] C_WEIGHT_B = 16'd19;

  // IDLE waits for an issue, CONV walks the four pixels, and DONE emits the
  // one-cycle completion pulse.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CONV = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] opa_q, opa_d;
  logic [31:0] opb_q, opb_d;
  logic [31:0] pack_q, pack_d;
  logic        done_q, done_d;
  logic [31:0] result_q, result_d;

  logic        accept_w;
  logic [15:0] pix_w;
  logic [15:0] r_ext_w;
  logic [15:0] g_ext_w;
  logic [15:0] b_ext_w;
  logic [15:0] sum_w;
  logic [7:0]  gray_w;

  // The instruction is taken only when idle and addressed to this block.
  // A start in any other state, or carrying another ID, has no effect.
  assign accept_w = start && (iseId == customInstructionId) && (state_q == ST_IDLE);

  // Pick the pixel for the current step from the latched operands.
  always_comb begin
    pix_w = 16'h0000;
    case (cnt_q)
      2'd0:    pix_w = opa_q[15:0];
      2'd1:    pix_w = opa_q[31:16];
      2'd2:    pix_w = opb_q[15:0];
      default: pix_w = opb_q[31:16];
    endcase
  end

  // Shared weighting datapath: three constant multiplies and one adder.
  // The largest possible sum is 13792, so 16 bits cannot overflow.
  assign r_ext_w = {11'd0, pix_w[15:11]};
  assign g_ext_w = {10'd0, pix_w[10:5]};
  assign b_ext_w = {11'd0, pix_w[4:0]};
  assign sum_w   = (r_ext_w * C_WEIGHT_R) + (g_ext_w * C_WEIGHT_G) + (b_ext_w * C_WEIGHT_B);
  assign gray_w  = 8'(sum_w >> 8);

  // Next-state logic. Outputs default to idle values, so result is zero in
  // every cycle that does not carry the completion pulse.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    pack_d   = pack_q;
    done_d   = 1'b0;
    result_d = 32'h0000_0000;

    case (state_q)
      ST_IDLE: begin
        if (accept_w) begin
          opa_d   = valueA;
          opb_d   = valueB;
          pack_d  = 32'h0000_0000;
          cnt_d   = 2'd0;
          state_d = ST_CONV;
        end
      end

      ST_CONV: begin
        case (cnt_q)
          2'd0:    pack_d[7:0]   = gray_w;
          2'd1:    pack_d[15:8]  = gray_w;
          2'd2:    pack_d[23:16] = gray_w;
          default: pack_d[31:24] = gray_w;
        endcase
        if (cnt_q == 2'd3) begin
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end

      ST_DONE: begin
        done_d   = 1'b1;
        result_d = pack_q;
        state_d  = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers. Reset abandons any request in flight, so an
  // interrupted request never produces a completion pulse.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= 2'd0;
      opa_q    <= 32'h0000_0000;
      opb_q    <= 32'h0000_0000;
      pack_q   <= 32'h0000_0000;
      done_q   <= 1'b0;
      result_q <= 32'h0000_0000;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      pack_q   <= pack_d;
      done_q   <= done_d;
      result_q <= result_d;
    end
  end

  assign done   = done_q;
  assign result = result_q;

endmodule
`default_nettype wire
